vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_gen.sv | 147 ++++++++++++++
 tb/tb_vga_timing_gen.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel divider, h/v counters, registered syncs,
// blanking flags and a frame counter, all freezable with enable.
module vga_timing_gen #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   PIX_DIV  = 2,
  parameter int   CW       = 10
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          enable,
  output logic          pixel_clk,
  output logic          pixel_ce,
  output logic          hs,
  output logic          vs,
  output logic          blank,
  output logic [CW-1:0] DrawX,
  output logic [CW-1:0] DrawY,
  output logic          frame_start,
  output logic          vblank,
  output logic [15:0]   frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  localparam logic [DW-1:0] DIV_MAX  = DW'(PIX_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(PIX_DIV / 2);
  localparam logic [DW-1:0] DIV_ONE  = DW'(1);
  localparam logic [CW-1:0] C_ZERO   = CW'(0);
  localparam logic [CW-1:0] C_ONE    = CW'(1);
  localparam logic [CW-1:0] H_MAX    = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_MAX    = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_VIS    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_VIS    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [DW-1:0] div_r, div_nxt_s;
  logic [CW-1:0] hc_r, vc_r, hc_nxt_s, vc_nxt_s;
  logic [15:0]   fc_r;
  logic          pixel_ce_r, pixel_clk_r, hs_r, vs_r, blank_r, vblank_r, frame_start_r;
  logic          advance_s, wrap_s, hs_nxt_s, vs_nxt_s;

  // Next divider/counter state and the sync levels that go with it.
  always_comb begin
    div_nxt_s = div_r;
    hc_nxt_s  = hc_r;
    vc_nxt_s  = vc_r;
    advance_s = 1'b0;
    wrap_s    = 1'b0;
    hs_nxt_s  = ~HS_POL;
    vs_nxt_s  = ~VS_POL;
    // A freeze landing on the last divider phase cleared pixel_ce; hold the
    // phase one cycle to re-issue the pulse so the pixel is neither lost nor doubled.
    if (div_r == DIV_MAX) begin
      if (pixel_ce_r) begin
        div_nxt_s = '0;
        advance_s = 1'b1;
      end else begin
        div_nxt_s = div_r;
      end
    end else begin
      div_nxt_s = div_r + DIV_ONE;
    end
    if (advance_s) begin
      if (hc_r == H_MAX) begin
        hc_nxt_s = C_ZERO;
        if (vc_r == V_MAX) begin
          vc_nxt_s = C_ZERO;
          wrap_s   = 1'b1;
        end else begin
          vc_nxt_s = vc_r + C_ONE;
        end
      end else begin
        hc_nxt_s = hc_r + C_ONE;
      end
    end else begin
      hc_nxt_s = hc_r;
    end
    if ((hc_nxt_s >= HS_START) && (hc_nxt_s <= HS_END)) begin
      hs_nxt_s = HS_POL;
    end else begin
      hs_nxt_s = ~HS_POL;
    end
    if ((vc_nxt_s >= VS_START) && (vc_nxt_s <= VS_END)) begin
      vs_nxt_s = VS_POL;
    end else begin
      vs_nxt_s = ~VS_POL;
    end
  end

  // State and output registers; enable=0 holds everything except the pulses.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      div_r         <= '0;
      hc_r          <= C_ZERO;
      vc_r          <= C_ZERO;
      fc_r          <= 16'd0;
      pixel_ce_r    <= 1'b0;
      pixel_clk_r   <= 1'b0;
      frame_start_r <= 1'b0;
      hs_r          <= ~HS_POL;
      vs_r          <= ~VS_POL;
      blank_r       <= 1'b1;
      vblank_r      <= 1'b0;
    end else if (enable) begin
      div_r         <= div_nxt_s;
      hc_r          <= hc_nxt_s;
      vc_r          <= vc_nxt_s;
      fc_r          <= wrap_s ? (fc_r + 16'd1) : fc_r;
      pixel_ce_r    <= (div_nxt_s == DIV_MAX);
      pixel_clk_r   <= (div_nxt_s >= DIV_HALF);
      frame_start_r <= wrap_s;
      hs_r          <= hs_nxt_s;
      vs_r          <= vs_nxt_s;
      blank_r       <= (hc_nxt_s < H_VIS) && (vc_nxt_s < V_VIS);
      vblank_r      <= (vc_nxt_s >= V_VIS);
    end else begin
      pixel_ce_r    <= 1'b0;
      frame_start_r <= 1'b0;
    end
  end

  assign pixel_clk   = pixel_clk_r;
  assign pixel_ce    = pixel_ce_r;
  assign hs          = hs_r;
  assign vs          = vs_r;
  assign blank       = blank_r;
  assign vblank      = vblank_r;
  assign DrawX       = hc_r;
  assign DrawY       = vc_r;
  assign frame_start = frame_start_r;
  assign frame_count = fc_r;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench: a default 640x480 instance and a tiny 14x7 instance,
// each checked every cycle against a scoreboard of modelled expectations.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic rst_a, en_a, rst_b, en_b;

  logic        a_pclk, a_pce, a_hs, a_vs, a_blank, a_vblank, a_fs;
  logic [9:0]  a_x, a_y;
  logic [15:0] a_fc;
  logic        b_pclk, b_pce, b_hs, b_vs, b_blank, b_vblank, b_fs;
  logic [3:0]  b_x, b_y;
  logic [15:0] b_fc;

  vga_timing_gen dut_a (
    .Clk(clk), .Reset(rst_a), .enable(en_a),
    .pixel_clk(a_pclk), .pixel_ce(a_pce), .hs(a_hs), .vs(a_vs),
    .blank(a_blank), .DrawX(a_x), .DrawY(a_y), .frame_start(a_fs),
    .vblank(a_vblank), .frame_count(a_fc)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .PIX_DIV(4), .CW(4)
  ) dut_b (
    .Clk(clk), .Reset(rst_b), .enable(en_b),
    .pixel_clk(b_pclk), .pixel_ce(b_pce), .hs(b_hs), .vs(b_vs),
    .blank(b_blank), .DrawX(b_x), .DrawY(b_y), .frame_start(b_fs),
    .vblank(b_vblank), .frame_count(b_fc)
  );

  typedef struct {
    bit pce, pclk, hs, vs, blank, vblank, fs;
    int x, y, fc;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int t_a = 0, t_b = 0;
  int n_cmp = 0, n_bad = 0;

  // Expected outputs after t enabled edges since reset (no freeze on the last divider phase).
  function automatic exp_t model(int t, bit en_edge, int ha, int hf, int hsw, int hb,
                                 int va, int vf, int vsw, int vb, bit hp, bit vp, int p);
    exp_t e;
    int ht, vt, pix, hc, vc, fr;
    ht = ha + hf + hsw + hb;
    vt = va + vf + vsw + vb;
    fr = ht * vt;
    pix = t / p;
    hc = pix % ht;
    vc = (pix / ht) % vt;
    e.pce    = en_edge && ((t % p) == p - 1);
    e.pclk   = (t % p) >= (p / 2);
    e.hs     = (hc >= ha + hf && hc < ha + hf + hsw) ? hp : !hp;
    e.vs     = (vc >= va + vf && vc < va + vf + vsw) ? vp : !vp;
    e.blank  = (hc < ha) && (vc < va);
    e.vblank = (vc >= va);
    e.fs     = en_edge && (t > 0) && ((t % p) == 0) && ((pix % fr) == 0);
    e.x      = hc;
    e.y      = vc;
    e.fc     = (pix / fr) % 65536;
    return e;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic cmp_dut(string n, exp_t e, logic pce, logic pclk, logic hs, logic vs,
                         logic bl, logic vbl, logic fs, logic [31:0] x, logic [31:0] y,
                         logic [31:0] fc);
    chk({n, ".pixel_ce"}, {31'd0, pce}, {31'd0, e.pce});
    chk({n, ".pixel_clk"}, {31'd0, pclk}, {31'd0, e.pclk});
    chk({n, ".hs"}, {31'd0, hs}, {31'd0, e.hs});
    chk({n, ".vs"}, {31'd0, vs}, {31'd0, e.vs});
    chk({n, ".blank"}, {31'd0, bl}, {31'd0, e.blank});
    chk({n, ".vblank"}, {31'd0, vbl}, {31'd0, e.vblank});
    chk({n, ".frame_start"}, {31'd0, fs}, {31'd0, e.fs});
    chk({n, ".DrawX"}, x, e.x);
    chk({n, ".DrawY"}, y, e.y);
    chk({n, ".frame_count"}, fc, e.fc);
  endtask

  // One clock: drive inputs, push expectations, then pop and compare at negedge.
  task automatic step(bit ra, bit ea, bit rb, bit eb);
    exp_t e;
    rst_a = ra; en_a = ea; rst_b = rb; en_b = eb;
    if (ra) t_a = 0; else if (ea) t_a++;
    if (rb) t_b = 0; else if (eb) t_b++;
    q_a.push_back(model(t_a, !ra && ea, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, 2));
    q_b.push_back(model(t_b, !rb && eb, 8, 2, 2, 2, 4, 1, 1, 1, 1'b1, 1'b1, 4));
    @(posedge clk);
    @(negedge clk);
    e = q_a.pop_front();
    cmp_dut("A", e, a_pce, a_pclk, a_hs, a_vs, a_blank, a_vblank, a_fs, a_x, a_y, a_fc);
    e = q_b.pop_front();
    cmp_dut("B", e, b_pce, b_pclk, b_hs, b_vs, b_blank, b_vblank, b_fs, b_x, b_y, b_fc);
  endtask

  int hs_lo, pce_cnt, vs_hi, fs_cnt;

  initial begin
    rst_a = 1'b1; en_a = 1'b0; rst_b = 1'b1; en_b = 1'b0;
    @(negedge clk);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1);

    // Line 0 of the default instance: sync width and pixel rate.
    hs_lo = 0; pce_cnt = 0;
    while (t_a < 1600) begin
      step(1'b0, 1'b1, 1'b0, 1'b1);
      if (a_hs === 1'b0) hs_lo++;
      if (a_pce === 1'b1) pce_cnt++;
    end
    chk("A.hs_low_clks_line0", hs_lo, 192);
    chk("A.pixel_ce_line0", pce_cnt, 800);

    // Freeze the default instance 37 clocks at DrawX=300 on line 2.
    while (t_a < 2 * (2 * 800 + 300)) step(1'b0, 1'b1, 1'b0, 1'b1);
    chk("A.freeze_x", a_x, 300);
    repeat (37) step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    chk("A.resume_x", a_x, 301);

    // Reset the default instance mid-line inside the hsync pulse.
    while (t_a < 2 * (2 * 800 + 700) + 1) step(1'b0, 1'b1, 1'b0, 1'b1);
    chk("A.hs_before_reset", a_hs, 0);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    chk("A.hs_after_reset", a_hs, 1);
    chk("A.x_after_reset", a_x, 0);

    // Freeze the small instance 37 clocks, then reset it while hs and vs are asserted.
    while ((t_b % 4) != 1) step(1'b0, 1'b1, 1'b0, 1'b1);
    repeat (37) step(1'b0, 1'b1, 1'b0, 1'b0);
    while (!(((t_b / 4) % 98) == 80 && (t_b % 4) == 2)) step(1'b0, 1'b1, 1'b0, 1'b1);
    chk("B.hs_before_reset", b_hs, 1);
    chk("B.vs_before_reset", b_vs, 1);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    chk("B.fc_after_reset", b_fc, 0);

    // One full small frame from reset: vsync width and single frame_start.
    vs_hi = 0; fs_cnt = 0;
    while (t_b < 392) begin
      step(1'b0, 1'b1, 1'b0, 1'b1);
      if (b_vs === 1'b1) vs_hi++;
      if (b_fs === 1'b1) fs_cnt++;
    end
    chk("B.vs_high_clks", vs_hi, 56);
    chk("B.frame_start_pulses", fs_cnt, 1);
    chk("B.frame_count_1", b_fc, 1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    chk("B.frame_start_one_clk", {31'd0, b_fs}, 0);
    repeat (400) step(1'b0, 1'b1, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
